imm_extend_unit: RTL and testbench

- Parametrised, pipelined immediate generator for the decode stage of the 8-bit pipelined core.
- Widens an IN_W-bit instruction immediate to OUT_W bits using a selectable mode: zero-extend, sign-extend or upper placement.
- Supports a prefix mechanism: a prefix transaction deposits PFX_W upper bits, which are concatenated onto the next immediate.
- Registered output with valid/ready handshake and a flush input for branch redirect.

---
 rtl/imm_extend_unit.sv | 173 +++++++++++++++++
 tb/tb_imm_extend_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_unit.sv
// ---------------------------------------------------------------------------
// imm_extend_unit
//    Pipelined immediate generator for the decode stage. Widens an IN_W-bit
//    immediate to OUT_W bits (zero-extend, sign-extend or upper placement),
//    optionally prefixed by PFX_W upper bits deposited by an earlier prefix
//    transaction. The result is registered behind a valid/ready handshake.
//
// Ports:
//    clk, rst        clock, synchronous active-high reset
//    flush           drop held output and any pending prefix
//    in_valid/ready  input handshake (in_ready = !out_valid || out_ready)
//    imm_in          raw immediate field
//    pfx_in          prefix bits, used when pfx_load=1
//    pfx_load        transaction is a prefix (produces no output)
//    mode            00 zero, 01 sign, 10 upper, 11 treated as 01
//    out_valid/ready output handshake
//    imm_out         extended immediate
//    pfx_pending     a prefix is stored and awaiting its immediate
//    err             (IMM_EXTEND_ERR_EN only) sticky: reserved mode used or
//                    a pending prefix was overwritten; cleared only by rst
//
// Build option: define IMM_EXTEND_ERR_EN to add the err output.
// Parameters must satisfy IN_W + PFX_W <= OUT_W.
// ---------------------------------------------------------------------------
module imm_extend_unit #(
   parameter int unsigned IN_W  = 3,
   parameter int unsigned PFX_W = 5,
   parameter int unsigned OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  imm_in,
   input  logic [PFX_W-1:0] pfx_in,
   input  logic             pfx_load,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] imm_out,
   output logic             pfx_pending
`ifdef IMM_EXTEND_ERR_EN
   ,
   output logic             err
`endif
);

   localparam int unsigned LONG_W = PFX_W + IN_W;
   localparam int unsigned PAD_S  = OUT_W - IN_W;

   typedef enum logic {
      NO_PFX   = 1'b0,
      PFX_HELD = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [PFX_W-1:0]   pfx_q, pfx_d;
   logic               out_valid_q, out_valid_d;
   logic [OUT_W-1:0]   imm_out_q, imm_out_d;

   logic               accept;
   logic [OUT_W-1:0]   short_ext;
   logic [OUT_W-1:0]   long_ext;
   logic [LONG_W-1:0]  v_long;

   // Extension of the bare immediate (no prefix held)
   always_comb begin
      short_ext = '0;
      case (mode)
         2'b00:   short_ext = {{PAD_S{1'b0}}, imm_in};
         2'b10:   short_ext = {imm_in, {PAD_S{1'b0}}};
         default: short_ext = {{PAD_S{imm_in[IN_W-1]}}, imm_in};
      endcase
   end

   // Extension of the prefixed immediate; when it already fills the word the
   // mode has no effect, which also avoids zero-width replications.
   always_comb v_long = {pfx_q, imm_in};

   generate
      if (LONG_W == OUT_W) begin : g_long_full
         always_comb long_ext = v_long;
      end else begin : g_long_pad
         localparam int unsigned PAD_L = OUT_W - LONG_W;
         always_comb begin
            long_ext = '0;
            case (mode)
               2'b00:   long_ext = {{PAD_L{1'b0}}, v_long};
               2'b10:   long_ext = {v_long, {PAD_L{1'b0}}};
               default: long_ext = {{PAD_L{v_long[LONG_W-1]}}, v_long};
            endcase
         end
      end
   endgenerate

   always_comb begin
      in_ready    = !out_valid_q || out_ready;
      out_valid   = out_valid_q;
      imm_out     = imm_out_q;
      pfx_pending = (state_q == PFX_HELD);
   end

   // Flush wins over a simultaneous input, so the input is never accepted.
   always_comb accept = in_valid && in_ready && !flush;

   always_comb begin
      state_d     = state_q;
      pfx_d       = pfx_q;
      out_valid_d = out_valid_q;
      imm_out_d   = imm_out_q;

      if (flush) begin
         out_valid_d = 1'b0;
         state_d     = NO_PFX;
      end else begin
         if (out_ready) begin
            out_valid_d = 1'b0;
         end
         if (accept) begin
            if (pfx_load) begin
               pfx_d   = pfx_in;
               state_d = PFX_HELD;
            end else begin
               out_valid_d = 1'b1;
               imm_out_d   = (state_q == PFX_HELD) ? long_ext : short_ext;
               state_d     = NO_PFX;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= NO_PFX;
         pfx_q       <= '0;
         out_valid_q <= 1'b0;
         imm_out_q   <= '0;
      end else begin
         state_q     <= state_d;
         pfx_q       <= pfx_d;
         out_valid_q <= out_valid_d;
         imm_out_q   <= imm_out_d;
      end
   end

`ifdef IMM_EXTEND_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (accept) begin
         if (pfx_load && (state_q == PFX_HELD)) begin
            err_d = 1'b1;
         end
         if (!pfx_load && (mode == 2'b11)) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   always_comb err = err_q;
`endif

endmodule

// File: tb/tb_imm_extend_unit.sv
// ---------------------------------------------------------------------------
// tb_imm_extend_unit
//    Self-checking bench for imm_extend_unit (default parameters). A
//    behavioural model tracks the expected outputs as integers; a negedge
//    process compares every cycle, and directed scenarios pin literal values.
//    Build with IMM_EXTEND_ERR_EN defined to also exercise the err output.
// ---------------------------------------------------------------------------
module tb_imm_extend_unit;

   localparam int IN_W  = 3;
   localparam int PFX_W = 5;
   localparam int OUT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  imm_in;
   logic [PFX_W-1:0] pfx_in;
   logic             pfx_load;
   logic [1:0]       mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] imm_out;
   logic             pfx_pending;
`ifdef IMM_EXTEND_ERR_EN
   logic             err;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   imm_extend_unit #(
      .IN_W (IN_W),
      .PFX_W(PFX_W),
      .OUT_W(OUT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .imm_in     (imm_in),
      .pfx_in     (pfx_in),
      .pfx_load   (pfx_load),
      .mode       (mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .imm_out    (imm_out),
      .pfx_pending(pfx_pending)
`ifdef IMM_EXTEND_ERR_EN
      ,
      .err        (err)
`endif
   );

   // ---------------- behavioural model ----------------
   // Extends value v of width w to OUT_W bits using integer arithmetic.
   function automatic int extend(input int v, input int w, input int m);
      int top;
      top = 1 << OUT_W;
      if (w == OUT_W) return v;
      if (m == 0) return v;
      if (m == 2) return (v << (OUT_W - w)) % top;
      if (v >= (1 << (w - 1))) return v - (1 << w) + top;
      return v;
   endfunction

   bit m_live = 0;
   bit m_valid, m_pend, m_err;
   int m_out, m_pfx;

   always @(posedge clk) begin
      bit rdy;
      if (rst) begin
         m_live  = 1;
         m_valid = 0;
         m_pend  = 0;
         m_err   = 0;
         m_out   = 0;
         m_pfx   = 0;
      end else if (m_live) begin
         rdy = !m_valid || out_ready;
         if (flush) begin
            m_valid = 0;
            m_pend  = 0;
         end else begin
            if (out_ready) m_valid = 0;
            if (in_valid && rdy) begin
               if (pfx_load) begin
                  if (m_pend) m_err = 1;
                  m_pfx  = int'(pfx_in);
                  m_pend = 1;
               end else begin
                  if (mode == 2'b11) m_err = 1;
                  if (m_pend)
                     m_out = extend(m_pfx * (1 << IN_W) + int'(imm_in), PFX_W + IN_W, int'(mode));
                  else
                     m_out = extend(int'(imm_in), IN_W, int'(mode));
                  m_valid = 1;
                  m_pend  = 0;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (m_live && !rst) begin
         chk("m_out_valid", int'(out_valid), int'(m_valid));
         chk("m_pfx_pending", int'(pfx_pending), int'(m_pend));
         chk("m_in_ready", int'(in_ready), int'(!m_valid || out_ready));
         if (m_valid) chk("m_imm_out", int'(imm_out), m_out);
`ifdef IMM_EXTEND_ERR_EN
         chk("m_err", int'(err), int'(m_err));
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic pl, input logic [IN_W-1:0] imm,
                         input logic [PFX_W-1:0] pfx, input logic [1:0] md);
      in_valid = v;
      pfx_load = pl;
      imm_in   = imm;
      pfx_in   = pfx;
      mode     = md;
   endtask

   initial begin
      logic [7:0] mode_exp [4];
      mode_exp[0] = 8'h05;
      mode_exp[1] = 8'hFD;
      mode_exp[2] = 8'hA0;
      mode_exp[3] = 8'hFD;

      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      set_in(1'b0, 1'b0, '0, '0, 2'b00);
      tick();
      tick();
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_imm_out", int'(imm_out), 8'h00);
      chk("reset_pfx_pending", int'(pfx_pending), 0);
      chk("reset_in_ready", int'(in_ready), 1);
      rst = 1'b0;

      // Modes on consecutive cycles
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 1'b0, 3'b101, '0, 2'(i));
         tick();
         chk("mode_valid", int'(out_valid), 1);
         chk("mode_imm_out", int'(imm_out), int'(mode_exp[i]));
      end
      set_in(1'b0, 1'b0, '0, '0, 2'b00);
      tick();
      chk("mode_drain", int'(out_valid), 0);

      // Prefix then immediate
      set_in(1'b1, 1'b1, 3'b000, 5'b10110, 2'b00);
      tick();
      chk("pfx_pending_set", int'(pfx_pending), 1);
      chk("pfx_no_output", int'(out_valid), 0);
      set_in(1'b1, 1'b0, 3'b011, 5'b00000, 2'b00);
      tick();
      chk("pfx_pending_clr", int'(pfx_pending), 0);
      chk("pfx_valid", int'(out_valid), 1);
      chk("pfx_imm_out", int'(imm_out), 8'hB3);
      set_in(1'b0, 1'b0, '0, '0, 2'b00);
      tick();

      // Backpressure
      set_in(1'b1, 1'b0, 3'b101, '0, 2'b01);
      tick();
      chk("bp_first", int'(imm_out), 8'hFD);
      out_ready = 1'b0;
      set_in(1'b1, 1'b0, 3'b010, '0, 2'b00);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_in_ready", int'(in_ready), 0);
         chk("bp_hold", int'(imm_out), 8'hFD);
         chk("bp_valid", int'(out_valid), 1);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_release", int'(imm_out), 8'h02);

      // Flush with output valid and input present
      set_in(1'b1, 1'b0, 3'b001, '0, 2'b00);
      flush = 1'b1;
      out_ready = 1'b0;
      tick();
      chk("flush_valid_drop", int'(out_valid), 0);
      out_ready = 1'b1;
      flush = 1'b0;

      // Flush with a prefix pending and an input present
      set_in(1'b1, 1'b1, 3'b000, 5'b11011, 2'b00);
      tick();
      chk("flush_pfx_set", int'(pfx_pending), 1);
      set_in(1'b1, 1'b0, 3'b101, '0, 2'b00);
      flush = 1'b1;
      tick();
      chk("flush_out_valid", int'(out_valid), 0);
      chk("flush_pfx_clr", int'(pfx_pending), 0);
      flush = 1'b0;
      set_in(1'b1, 1'b0, 3'b111, '0, 2'b01);
      tick();
      chk("post_flush_imm", int'(imm_out), 8'hFF);
      set_in(1'b0, 1'b0, '0, '0, 2'b00);
      tick();

`ifdef IMM_EXTEND_ERR_EN
      set_in(1'b1, 1'b1, 3'b000, 5'b00001, 2'b00);
      tick();
      chk("err_first_pfx", int'(err), 0);
      set_in(1'b1, 1'b1, 3'b000, 5'b11111, 2'b00);
      tick();
      chk("err_overwrite", int'(err), 1);
      set_in(1'b1, 1'b0, 3'b000, '0, 2'b00);
      tick();
      chk("err_imm_out", int'(imm_out), 8'hF8);
      set_in(1'b0, 1'b0, '0, '0, 2'b00);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("err_sticky_flush", int'(err), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("err_rst_clear", int'(err), 0);
`endif

      // Randomised traffic checked by the model
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 199) == 0);
         flush     = ($urandom_range(0, 24) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         set_in(1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0),
                IN_W'($urandom),
                PFX_W'($urandom),
                2'($urandom_range(0, 3)));
         tick();
      end

      rst = 1'b0; flush = 1'b0;
      set_in(1'b0, 1'b0, '0, '0, 2'b00);
      tick();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
